// File: rtl/echo_pulse_receiver_pkg.sv
// echo_pulse_receiver_pkg: status codes, FSM encoding and 20 MHz timing
// defaults shared by the echo receive path.
package echo_pulse_receiver_pkg;

  localparam int CLK_HZ        = 20_000_000;
  localparam int CYCLES_PER_MS = CLK_HZ / 1000;

  localparam int DEF_W            = 20;
  localparam int DEF_SYNC_STAGES  = 2;
  localparam int DEF_RISE_TIMEOUT = CYCLES_PER_MS;       // 1 ms arm-to-rise window
  localparam int DEF_MAX_ECHO     = 38 * CYCLES_PER_MS;  // 38 ms echo ceiling
  localparam int DEF_MIN_PULSE    = 4;

  typedef enum logic [1:0] {
    ST_OK        = 2'b00,
    ST_NO_ECHO   = 2'b01,
    ST_OVERRANGE = 2'b10,
    ST_STUCK     = 2'b11
  } echo_status_t;

  typedef enum logic [1:0] {
    FSM_IDLE      = 2'b00,
    FSM_WAIT_RISE = 2'b01,
    FSM_MEASURE   = 2'b10,
    FSM_HOLDOFF   = 2'b11
  } fsm_state_t;

endpackage

// File: rtl/echo_pulse_receiver_sync_edge_detect.sv
// echo_pulse_receiver_sync_edge_detect: multi-flop synchroniser for the raw
// ECHO line plus single-cycle rise/fall flags on the synchronised level.
module echo_pulse_receiver_sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dout_prev;

  // shift the async input through the chain; keep one extra copy for edges
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q    <= '0;
      dout_prev <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], din};
      dout_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  assign dout = sync_q[SYNC_STAGES-1];
  assign rise = dout & ~dout_prev;
  assign fall = ~dout & dout_prev;

endmodule

// File: rtl/echo_pulse_receiver.sv
// echo_pulse_receiver: times the ultrasonic sensor ECHO pulse after each arm
// (trigger_done) and reports one width/status result per accepted arm.
//
//  state      | meaning
//  -----------+-------------------------------------------------------------
//  IDLE       | waiting for arm; arm with echo already high reports STUCK
//  WAIT_RISE  | armed, rise_cnt running, waiting for echo to go high
//  MEASURE    | echo high, width_cnt counting; short highs drop back as glitch
//  HOLDOFF    | overrange reported, waiting for echo to fall before re-arming
module echo_pulse_receiver
  import echo_pulse_receiver_pkg::*;
#(
  parameter int W            = DEF_W,
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int RISE_TIMEOUT = DEF_RISE_TIMEOUT,
  parameter int MAX_ECHO     = DEF_MAX_ECHO,
  parameter int MIN_PULSE    = DEF_MIN_PULSE
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         arm,
  input  logic         echo_in,
  output logic         busy,
  output logic         result_valid,
  output logic [W-1:0] echo_width,
  output logic [1:0]   status
);

  localparam logic [W-1:0] RISE_LAST = W'(RISE_TIMEOUT - 1);
  localparam logic [W-1:0] MAX_W     = W'(MAX_ECHO);
  localparam logic [W-1:0] MIN_W     = W'(MIN_PULSE);
  localparam logic [W-1:0] CNT_ONE   = W'(1);
  localparam logic [W-1:0] CNT_SAT   = {W{1'b1}};

  logic echo_sync;
  logic echo_rise;
  logic echo_fall;

  fsm_state_t   state_q, state_d;
  logic [W-1:0] rise_cnt_q, rise_cnt_d;
  logic [W-1:0] width_cnt_q, width_cnt_d;
  logic [W-1:0] rise_inc, width_inc;
  logic         res_load;
  echo_status_t res_status;
  logic [W-1:0] res_width;

  echo_pulse_receiver_sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (echo_in),
    .dout  (echo_sync),
    .rise  (echo_rise),
    .fall  (echo_fall)
  );

  // Counters hold at all-ones rather than wrapping.
  assign rise_inc  = (rise_cnt_q  == CNT_SAT) ? rise_cnt_q  : rise_cnt_q  + 1'b1;
  assign width_inc = (width_cnt_q == CNT_SAT) ? width_cnt_q : width_cnt_q + 1'b1;

  // next-state, counter updates and result decision for the current cycle.
  // WAIT_RISE is only entered with echo_sync low and MEASURE only stays while
  // it is high, so rise/fall there are equivalent to the synchronised level.
  always_comb begin
    state_d     = state_q;
    rise_cnt_d  = rise_cnt_q;
    width_cnt_d = width_cnt_q;
    res_load    = 1'b0;
    res_status  = ST_OK;
    res_width   = '0;
    case (state_q)
      FSM_IDLE: begin
        if (arm) begin
          if (echo_sync) begin
            res_load   = 1'b1;
            res_status = ST_STUCK;
          end else begin
            state_d    = FSM_WAIT_RISE;
            rise_cnt_d = '0;
          end
        end
      end
      FSM_WAIT_RISE: begin
        rise_cnt_d = rise_inc;
        if (echo_rise) begin
          state_d     = FSM_MEASURE;
          width_cnt_d = CNT_ONE;
        end else if (rise_cnt_q >= RISE_LAST) begin
          // >= so a timeout overrun during a glitch still ends the attempt
          res_load   = 1'b1;
          res_status = ST_NO_ECHO;
          state_d    = FSM_IDLE;
        end
      end
      FSM_MEASURE: begin
        rise_cnt_d = rise_inc;
        if (!echo_fall) begin
          if (width_cnt_q == MAX_W) begin
            res_load   = 1'b1;
            res_status = ST_OVERRANGE;
            res_width  = MAX_W;
            state_d    = FSM_HOLDOFF;
          end else begin
            width_cnt_d = width_inc;
          end
        end else if (width_cnt_q >= MIN_W) begin
          res_load   = 1'b1;
          res_status = ST_OK;
          res_width  = width_cnt_q;
          state_d    = FSM_IDLE;
        end else begin
          state_d = FSM_WAIT_RISE;
        end
      end
      FSM_HOLDOFF: begin
        if (!echo_sync) begin
          state_d = FSM_IDLE;
        end
      end
      default: state_d = FSM_IDLE;
    endcase
  end

  // state, counters and registered result outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FSM_IDLE;
      rise_cnt_q   <= '0;
      width_cnt_q  <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      echo_width   <= '0;
      status       <= 2'b00;
    end else begin
      state_q      <= state_d;
      rise_cnt_q   <= rise_cnt_d;
      width_cnt_q  <= width_cnt_d;
      busy         <= (state_d != FSM_IDLE);
      result_valid <= res_load;
      if (res_load) begin
        echo_width <= res_width;
        status     <= res_status;
      end
    end
  end

endmodule

// File: tb/tb_echo_pulse_receiver.sv
// tb_echo_pulse_receiver: directed scenarios followed by randomized arm/echo
// traffic, checked every cycle against an event-scanning reference model.
module tb_echo_pulse_receiver;

  localparam int W    = 20;
  localparam int SYNC = 2;
  localparam int RT   = 100;
  localparam int MAXE = 1000;
  localparam int MINP = 4;
  localparam int NCYC = 40000;

  logic         clk = 1'b0;
  logic         reset;
  logic         arm;
  logic         echo_in;
  logic         busy;
  logic         result_valid;
  logic [W-1:0] echo_width;
  logic [1:0]   status;

  echo_pulse_receiver #(
    .W            (W),
    .SYNC_STAGES  (SYNC),
    .RISE_TIMEOUT (RT),
    .MAX_ECHO     (MAXE),
    .MIN_PULSE    (MINP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .arm          (arm),
    .echo_in      (echo_in),
    .busy         (busy),
    .result_valid (result_valid),
    .echo_width   (echo_width),
    .status       (status)
  );

  always #25 clk = ~clk;

  // stimulus: index k is the value sampled at rising edge k
  bit rst_a [NCYC];
  bit arm_a [NCYC];
  bit echo_a[NCYC];
  int pos;

  // expected outputs during the cycle following edge k
  bit exp_valid[NCYC];
  bit exp_busy [NCYC];
  int exp_w    [NCYC];
  int exp_s    [NCYC];

  int cur_w, cur_s, last_rst;
  int checks   = 0;
  int failures = 0;
  int edge_idx = -1;
  bit running  = 1'b0;
  int rand_start;
  int s2_arm;
  int res_cyc[$];
  int res_w[$];
  int res_s[$];

  task automatic seg(input int n, input bit a, input bit e, input bit r);
    for (int i = 0; i < n; i++) begin
      if (pos < NCYC) begin
        rst_a[pos]  = r;
        arm_a[pos]  = a;
        echo_a[pos] = e;
        pos++;
      end
    end
  endtask

  task automatic rand_txn();
    int start, np, sel, w, st, len;
    bit stuck;
    start = pos;
    seg(int'($urandom_range(1, 6)), 1'b0, 1'b0, 1'b0);
    stuck = ($urandom_range(0, 9) == 0);
    if (stuck) seg(int'($urandom_range(1, 4)), 1'b0, 1'b1, 1'b0);
    seg(1, 1'b1, stuck, 1'b0);
    seg(int'($urandom_range(0, 110)), 1'b0, 1'b0, 1'b0);
    np = int'($urandom_range(0, 3));
    for (int p = 0; p < np; p++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 3)      w = int'($urandom_range(1, 5));
      else if (sel < 9) w = int'($urandom_range(4, 80));
      else              w = int'($urandom_range(995, 1005));
      seg(w, 1'b0, 1'b1, 1'b0);
      seg(int'($urandom_range(1, 20)), 1'b0, 1'b0, 1'b0);
    end
    seg(int'($urandom_range(0, 10)), 1'b0, 1'b0, 1'b0);
    if ($urandom_range(0, 2) == 0) begin
      st  = int'($urandom_range(start + 1, pos - 1));
      len = int'($urandom_range(1, 40));
      for (int i = 0; i < len; i++) if (st + i < NCYC) arm_a[st + i] = 1'b1;
    end
    if ($urandom_range(0, 9) == 0) rst_a[int'($urandom_range(start + 1, pos - 1))] = 1'b1;
  endtask

  // echo level the receiver acts on at edge c: echo_in SYNC edges earlier,
  // zero while the synchroniser refills after a reset
  function automatic bit seen(input int c);
    if (c - SYNC < 0 || c - SYNC <= last_rst) return 1'b0;
    return echo_a[c - SYNC];
  endfunction

  function automatic void mark(input int c, input bit b, input bit v);
    exp_busy[c]  = b;
    exp_valid[c] = v;
    exp_w[c]     = cur_w;
    exp_s[c]     = cur_s;
  endfunction

  // one armed measurement starting at edge c0; returns the next edge at
  // which the receiver is idle again (or the edge of an aborting reset)
  function automatic int txn(input int c0);
    int t, j, u;
    mark(c0, 1'b1, 1'b0);
    t = c0 + 1;
    while (t < NCYC) begin
      if (rst_a[t]) return t;
      if (!seen(t)) begin
        if (t - c0 - 1 >= RT - 1) begin
          cur_s = 1; cur_w = 0;
          mark(t, 1'b0, 1'b1);
          return t + 1;
        end
        mark(t, 1'b1, 1'b0);
        t++;
      end else begin
        mark(t, 1'b1, 1'b0);
        j = 1;
        u = t + 1;
        while (1'b1) begin
          if (u >= NCYC) return NCYC;
          if (rst_a[u]) return u;
          if (!seen(u)) break;
          if (j == MAXE) begin
            cur_s = 2; cur_w = MAXE;
            mark(u, 1'b1, 1'b1);
            for (int h = u + 1; h < NCYC; h++) begin
              if (rst_a[h]) return h;
              if (!seen(h)) begin
                mark(h, 1'b0, 1'b0);
                return h + 1;
              end
              mark(h, 1'b1, 1'b0);
            end
            return NCYC;
          end
          mark(u, 1'b1, 1'b0);
          j++;
          u++;
        end
        if (j >= MINP) begin
          cur_s = 0; cur_w = j;
          mark(u, 1'b0, 1'b1);
          return u + 1;
        end
        mark(u, 1'b1, 1'b0);
        t = u + 1;
      end
    end
    return NCYC;
  endfunction

  function automatic void build_model();
    int c;
    c = 0; last_rst = -1000; cur_w = 0; cur_s = 0;
    while (c < NCYC) begin
      if (rst_a[c]) begin
        last_rst = c; cur_w = 0; cur_s = 0;
        mark(c, 1'b0, 1'b0);
        c++;
      end else if (arm_a[c] && seen(c)) begin
        cur_w = 0; cur_s = 3;
        mark(c, 1'b0, 1'b1);
        c++;
      end else if (arm_a[c]) begin
        c = txn(c);
      end else begin
        mark(c, 1'b0, 1'b0);
        c++;
      end
    end
  endfunction

  task automatic chk(input string name, input int cyc, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s at=%0d actual=%0d required=%0d", name, cyc, act, req);
    end
  endtask

  // cycle-by-cycle comparison against the model, away from the rising edge
  always @(negedge clk) begin
    if (running && edge_idx >= 0) begin
      chk("result_valid", edge_idx, int'(result_valid), int'(exp_valid[edge_idx]));
      chk("busy",         edge_idx, int'(busy),         int'(exp_busy[edge_idx]));
      chk("echo_width",   edge_idx, int'(echo_width),   exp_w[edge_idx]);
      chk("status",       edge_idx, int'(status),       exp_s[edge_idx]);
      if (result_valid === 1'b1) begin
        res_cyc.push_back(edge_idx);
        res_w.push_back(int'(echo_width));
        res_s.push_back(int'(status));
      end
    end
  end

  int lit_s[10] = '{0, 1, 2, 0, 3, 0, 0, 0, 0, 1};
  int lit_w[10] = '{300, 0, 1000, 50, 0, 300, 4, 1000, 10, 0};

  initial begin
    int n_model, n_det;
    pos = 0;
    seg(4, 1'b0, 1'b0, 1'b1);
    seg(10, 1'b0, 1'b0, 1'b0);
    // normal 300-cycle echo
    seg(1, 1'b1, 1'b0, 1'b0); seg(20, 1'b0, 1'b0, 1'b0);
    seg(300, 1'b0, 1'b1, 1'b0); seg(30, 1'b0, 1'b0, 1'b0);
    // no echo
    s2_arm = pos;
    seg(1, 1'b1, 1'b0, 1'b0); seg(130, 1'b0, 1'b0, 1'b0);
    // overrange with an arm during holdoff
    seg(1, 1'b1, 1'b0, 1'b0); seg(10, 1'b0, 1'b0, 1'b0);
    seg(1200, 1'b0, 1'b1, 1'b0); seg(1, 1'b1, 1'b1, 1'b0); seg(299, 1'b0, 1'b1, 1'b0);
    seg(30, 1'b0, 1'b0, 1'b0);
    // glitch then real pulse
    seg(1, 1'b1, 1'b0, 1'b0); seg(10, 1'b0, 1'b0, 1'b0); seg(2, 1'b0, 1'b1, 1'b0);
    seg(10, 1'b0, 1'b0, 1'b0); seg(50, 1'b0, 1'b1, 1'b0); seg(30, 1'b0, 1'b0, 1'b0);
    // stuck high
    seg(10, 1'b0, 1'b1, 1'b0); seg(1, 1'b1, 1'b1, 1'b0); seg(5, 1'b0, 1'b1, 1'b0);
    seg(20, 1'b0, 1'b0, 1'b0);
    // reset during measurement, then normal again
    seg(1, 1'b1, 1'b0, 1'b0); seg(10, 1'b0, 1'b0, 1'b0); seg(100, 1'b0, 1'b1, 1'b0);
    seg(2, 1'b0, 1'b1, 1'b1); seg(20, 1'b0, 1'b1, 1'b0); seg(20, 1'b0, 1'b0, 1'b0);
    seg(1, 1'b1, 1'b0, 1'b0); seg(20, 1'b0, 1'b0, 1'b0);
    seg(300, 1'b0, 1'b1, 1'b0); seg(30, 1'b0, 1'b0, 1'b0);
    // MIN_PULSE boundary: 3 is a glitch, 4 is accepted
    seg(1, 1'b1, 1'b0, 1'b0); seg(5, 1'b0, 1'b0, 1'b0); seg(3, 1'b0, 1'b1, 1'b0);
    seg(5, 1'b0, 1'b0, 1'b0); seg(4, 1'b0, 1'b1, 1'b0); seg(10, 1'b0, 1'b0, 1'b0);
    // exactly MAX_ECHO high is still OK
    seg(1, 1'b1, 1'b0, 1'b0); seg(5, 1'b0, 1'b0, 1'b0);
    seg(1000, 1'b0, 1'b1, 1'b0); seg(10, 1'b0, 1'b0, 1'b0);
    // rise on the last allowed edge, then one edge too late
    seg(1, 1'b1, 1'b0, 1'b0); seg(97, 1'b0, 1'b0, 1'b0);
    seg(10, 1'b0, 1'b1, 1'b0); seg(10, 1'b0, 1'b0, 1'b0);
    seg(1, 1'b1, 1'b0, 1'b0); seg(98, 1'b0, 1'b0, 1'b0);
    seg(10, 1'b0, 1'b1, 1'b0); seg(10, 1'b0, 1'b0, 1'b0);
    rand_start = pos;
    while (pos < NCYC - 3000) rand_txn();

    build_model();
    n_model = 0;
    for (int k = 0; k < NCYC; k++) if (exp_valid[k]) n_model++;

    reset   = rst_a[0];
    arm     = arm_a[0];
    echo_in = echo_a[0];
    running = 1'b1;
    for (int k = 0; k < NCYC; k++) begin
      @(posedge clk);
      edge_idx = k;
      #1;
      if (k + 1 < NCYC) begin
        reset   = rst_a[k + 1];
        arm     = arm_a[k + 1];
        echo_in = echo_a[k + 1];
      end else begin
        reset = 1'b0; arm = 1'b0; echo_in = 1'b0;
      end
    end
    @(negedge clk);
    #1;
    running = 1'b0;

    n_det = 0;
    foreach (res_cyc[i]) if (res_cyc[i] < rand_start) n_det++;
    chk("directed_result_count", 0, n_det, 10);
    for (int i = 0; i < 10; i++) begin
      if (i < res_cyc.size()) begin
        chk("directed_status", i, res_s[i], lit_s[i]);
        chk("directed_width",  i, res_w[i], lit_w[i]);
      end
    end
    if (res_cyc.size() > 1) chk("no_echo_latency", 1, res_cyc[1] - s2_arm, 100);
    chk("total_result_count", 0, res_cyc.size(), n_model);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
